// File: rtl/hsst_pkg.sv
// hsst_pkg: shared K-word constants, txk flags and FSM states for the HSST transmit framer
package hsst_pkg;
  localparam logic [7:0]  K28_5     = 8'hBC;
  localparam logic [7:0]  SOF_MARK  = 8'h01;
  localparam logic [31:0] IDLE_WORD = 32'hFF5555BC;
  localparam logic [31:0] EOF_WORD  = 32'hFF0002BC;
  localparam logic [3:0]  TXK_CTRL  = 4'b0001;
  localparam logic [3:0]  TXK_DATA  = 4'b0000;
  typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_DATA, ST_CSUM, ST_EOF, ST_GAP} state_t;
  function automatic logic [31:0] sof_word(input logic [7:0] seq, input logic [7:0] ch);
    return {seq, ch, SOF_MARK, K28_5};
  endfunction
endpackage

// File: rtl/hsst_word_fifo.sv
// hsst_word_fifo: synchronous first-word-fall-through FIFO of 32-bit lane words, depth 2**AW
module hsst_word_fifo #(
  parameter int AW = 7
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  output logic [31:0]   data_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [31:0]   mem_q [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = level_q[AW];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_q];
  // storage carries no reset; the pointers alone define what is valid
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q] <= data_i;
  // pointers and occupancy; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/hsst_frame_tx.sv
// hsst_frame_tx: byte packer, word FIFO and frame FSM for one HSST TX lane (HSST_TX_CHKSUM_EN adds a checksum word)
module hsst_frame_tx
  import hsst_pkg::*;
#(
  parameter int         FRAME_WORDS = 64,
  parameter int         FIFO_AW     = 7,
  parameter logic [7:0] CH_ID       = 8'h00,
  parameter int         IDLE_GAP    = 1
) (
  input  logic               tx_clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  input  logic               lane_rdy,
  output logic [31:0]        hsst_txd,
  output logic [3:0]         hsst_txk,
  output logic               frame_done,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               ovf
);
  localparam int GAP_W = $clog2(IDLE_GAP + 1);
  localparam logic [FIFO_AW:0] FW_L = (FIFO_AW + 1)'(FRAME_WORDS);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);
  logic [1:0]       bcnt_q;
  logic [23:0]      part_q;
  logic             ovf_q, accept, push, pop, full, empty, start;
  logic [31:0]      fifo_dout;
  state_t           state_q, state_d;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       seq_q, seq_d;
  logic [31:0]      txd_q, txd_d;
  logic [3:0]       txk_q, txk_d;
  logic             done_q, done_d;
`ifdef HSST_TX_CHKSUM_EN
  logic [31:0]      csum_q, csum_d;
`endif
  assign s_ready    = rst_n && !full;
  assign accept     = s_valid && s_ready;
  assign push       = accept && (bcnt_q == 2'd3);
  assign start      = lane_rdy && (fifo_level >= FW_L);
  assign ovf        = ovf_q;
  assign hsst_txd   = txd_q;
  assign hsst_txk   = txk_q;
  assign frame_done = done_q;
  hsst_word_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_i   (tx_clk),
    .rst_n_i (rst_n),
    .push_i  (push),
    .data_i  ({s_data, part_q}),
    .pop_i   (pop && !empty),
    .data_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (full),
    .empty_o (empty)
  );
  // byte packer: bytes shift in from the top so the first byte ends up in [7:0]; sticky overflow flag
  always_ff @(posedge tx_clk or negedge rst_n)
    if (!rst_n) begin
      bcnt_q <= '0;
      part_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        bcnt_q <= bcnt_q + 1'b1;
        part_q <= {s_data, part_q[23:8]};
      end
      ovf_q <= ovf_q | (s_valid & ~s_ready);
    end
  // frame sequencing; the bus word is chosen for the state being entered, so it lands with that state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    seq_d   = seq_q;
    pop     = 1'b0;
    txd_d   = IDLE_WORD;
    txk_d   = TXK_CTRL;
    done_d  = 1'b0;
`ifdef HSST_TX_CHKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: state_d = start ? ST_SOF : ST_IDLE;
      ST_SOF:  state_d = ST_DATA;
`ifdef HSST_TX_CHKSUM_EN
      ST_DATA: state_d = (cnt_q == FW_L) ? ST_CSUM : ST_DATA;
      ST_CSUM: state_d = ST_EOF;
`else
      ST_DATA: state_d = (cnt_q == FW_L) ? ST_EOF : ST_DATA;
`endif
      ST_EOF:  state_d = ST_GAP;
      ST_GAP:  state_d = (gap_q != GAP_LAST) ? ST_GAP : start ? ST_SOF : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_SOF: begin
        txd_d  = sof_word(seq_q, CH_ID);
        cnt_d  = '0;
`ifdef HSST_TX_CHKSUM_EN
        csum_d = '0;
`endif
      end
      ST_DATA: begin
        pop    = 1'b1;
        txd_d  = fifo_dout;
        txk_d  = TXK_DATA;
        cnt_d  = cnt_q + 1'b1;
`ifdef HSST_TX_CHKSUM_EN
        csum_d = csum_q + fifo_dout;
`endif
      end
`ifdef HSST_TX_CHKSUM_EN
      ST_CSUM: begin
        txd_d = csum_q;
        txk_d = TXK_DATA;
      end
`endif
      ST_EOF: begin
        txd_d  = EOF_WORD;
        done_d = 1'b1;
        seq_d  = seq_q + 1'b1;
      end
      ST_GAP:  gap_d = (state_q == ST_GAP) ? gap_q + 1'b1 : '0;
      default: ;
    endcase
  end
  // FSM state and registered lane outputs
  always_ff @(posedge tx_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      seq_q   <= '0;
      txd_q   <= '0;
      txk_q   <= '0;
      done_q  <= 1'b0;
`ifdef HSST_TX_CHKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      seq_q   <= seq_d;
      txd_q   <= txd_d;
      txk_q   <= txk_d;
      done_q  <= done_d;
`ifdef HSST_TX_CHKSUM_EN
      csum_q  <= csum_d;
`endif
    end
endmodule

// File: tb/tb_hsst_frame_tx.sv
// tb_hsst_frame_tx: randomized byte stream checked against a frame-level model of the lane output
module tb_hsst_frame_tx;
  localparam int         FW  = 4;
  localparam int         AW  = 3;
  localparam int         GAP = 3;
  localparam logic [7:0] CH  = 8'h5A;
  localparam logic [31:0] W_IDLE = 32'hFF5555BC;
  localparam logic [31:0] W_EOF  = 32'hFF0002BC;
  logic        tx_clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, lane_rdy = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, frame_done, ovf;
  logic [31:0] hsst_txd;
  logic [3:0]  hsst_txk;
  logic [AW:0] fifo_level;
  always #5 tx_clk = ~tx_clk;
  hsst_frame_tx #(.FRAME_WORDS(FW), .FIFO_AW(AW), .CH_ID(CH), .IDLE_GAP(GAP)) dut (
    .tx_clk     (tx_clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .lane_rdy   (lane_rdy),
    .hsst_txd   (hsst_txd),
    .hsst_txk   (hsst_txk),
    .frame_done (frame_done),
    .fifo_level (fifo_level),
    .ovf        (ovf)
  );
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // reference stream: every accepted byte is packed little-endian into expected data words
  logic [31:0] exp_words [8192];
  int          wr_idx = 0;
  logic [31:0] part = '0;
  int          part_n = 0;
  task automatic model_byte(input logic [7:0] b);
    part = part | (32'(b) << (8 * part_n));
    part_n++;
    if (part_n == 4) begin
      exp_words[wr_idx] = part;
      wr_idx++;
      part = '0;
      part_n = 0;
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge tx_clk);
    s_valid = 1'b1;
    s_data  = b;
    #1;
    while (!s_ready && n < 200) begin
      @(negedge tx_clk);
      #1;
      n++;
    end
    check("byte_accept", s_ready, 1'b1);
    if (s_ready) model_byte(b);
    @(posedge tx_clk);
    #1 s_valid = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask
  // frame monitor: parses the lane stream and checks it against the expected words and sequence
  logic        mon_en = 1'b0, in_frame = 1'b0, seen_eof = 1'b0, csum_done = 1'b0, mon_eof;
  int          rd_idx = 0, frames = 0, n_sof = 0, idle_cnt = 0, last_gap = 0, idx = 0;
  logic [7:0]  exp_seq = 8'h00;
  logic [31:0] sum = '0, last_csum = '0;
  always @(negedge tx_clk) begin
    if (!mon_en) begin
      rd_idx   = wr_idx;
      in_frame = 1'b0;
      seen_eof = 1'b0;
      exp_seq  = 8'h00;
      idle_cnt = 0;
    end else begin
      mon_eof = (hsst_txk == 4'b0001) && (hsst_txd == W_EOF);
      check("frame_done", frame_done, mon_eof);
      if (hsst_txk == 4'b0001 && hsst_txd == W_IDLE) begin
        check("idle_in_frame", in_frame, 1'b0);
        idle_cnt++;
      end else if (hsst_txk == 4'b0001 && hsst_txd[15:0] == 16'h01BC) begin
        check("sof_word", hsst_txd, {exp_seq, CH, 16'h01BC});
        check("sof_in_frame", in_frame, 1'b0);
        if (seen_eof) check("gap_min", idle_cnt >= GAP, 1'b1);
        last_gap  = idle_cnt;
        n_sof++;
        in_frame  = 1'b1;
        idx       = 0;
        sum       = '0;
        csum_done = 1'b0;
      end else if (hsst_txk == 4'b0000 && in_frame && idx < FW) begin
        check("data_avail", rd_idx < wr_idx, 1'b1);
        check("data_word", hsst_txd, exp_words[rd_idx]);
        rd_idx++;
        idx++;
        sum += hsst_txd;
      end
`ifdef HSST_TX_CHKSUM_EN
      else if (hsst_txk == 4'b0000 && in_frame && !csum_done) begin
        check("csum_word", hsst_txd, sum);
        last_csum = hsst_txd;
        csum_done = 1'b1;
      end
`endif
      else if (mon_eof) begin
        check("eof_len", idx, FW);
        check("eof_in_frame", in_frame, 1'b1);
`ifdef HSST_TX_CHKSUM_EN
        check("eof_after_csum", csum_done, 1'b1);
`endif
        exp_seq++;
        frames++;
        in_frame = 1'b0;
        seen_eof = 1'b1;
        idle_cnt = 0;
      end else check("bus_word", {hsst_txk, hsst_txd}, {4'b0001, W_IDLE});
    end
  end
  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 3000) begin
      @(negedge tx_clk);
      n++;
    end
    check("frames_reached", frames >= target, 1'b1);
  endtask
  initial begin
    int f0, s0, n;
    repeat (3) @(negedge tx_clk);
    check("rst_txd", hsst_txd, 32'd0);
    check("rst_txk", hsst_txk, 4'd0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge tx_clk);
    check("first_idle", {hsst_txk, hsst_txd}, {4'b0001, W_IDLE});
    check("ready_after_rst", s_ready, 1'b1);
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'(i));
    repeat (5) @(negedge tx_clk);
    check("partial_level", fifo_level, 0);
    check("partial_idle", {hsst_txk, hsst_txd}, {4'b0001, W_IDLE});
    send_byte(8'h03);
    check("level_after_4th", fifo_level, 1);
    lane_rdy = 1'b1;
    for (int i = 4; i < 16; i++) send_byte(8'(i));
    wait_frames(1);
    lane_rdy = 1'b0;
    repeat (12) @(negedge tx_clk);
    for (int i = 0; i < 32; i++) send_byte(8'($urandom));
    @(negedge tx_clk);
    check("full_level", fifo_level, 8);
    check("full_not_ready", s_ready, 1'b0);
    check("ovf_clear", ovf, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hEE;
    @(negedge tx_clk);
    s_valid = 1'b0;
    check("ovf_set", ovf, 1'b1);
    repeat (5) @(negedge tx_clk);
    check("ovf_sticky", ovf, 1'b1);
    s0 = n_sof;
    lane_rdy = 1'b1;
    @(negedge tx_clk);
    check("sof_start", {hsst_txk, hsst_txd}, {4'b0001, 8'(frames), CH, 16'h01BC});
    n = 0;
    while (n_sof < s0 + 2 && n < 100) begin
      @(negedge tx_clk);
      n++;
    end
    check("gap_exact", last_gap, GAP);
    wait_frames(3);
    for (int i = 0; i < 256 * 16; i++) begin
      lane_rdy = ($urandom_range(7) != 0);
      send_byte(8'($urandom));
    end
    lane_rdy = 1'b1;
    wait_frames(259);
    check("ovf_still_set", ovf, 1'b1);
`ifdef HSST_TX_CHKSUM_EN
    f0 = frames;
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    send_word(32'hFFFFFFFF);
    wait_frames(f0 + 1);
    check("csum_directed", last_csum, 32'h5);
`endif
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    n = 0;
    while (hsst_txk != 4'b0000 && n < 100) begin
      @(negedge tx_clk);
      n++;
    end
    check("reached_data", hsst_txk, 4'b0000);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_txd", hsst_txd, 32'd0);
    check("midrst_txk", hsst_txk, 4'd0);
    check("midrst_level", fifo_level, 0);
    check("midrst_ready", s_ready, 1'b0);
    check("midrst_done", frame_done, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    part   = '0;
    part_n = 0;
    @(negedge tx_clk);
    rst_n = 1'b1;
    @(negedge tx_clk);
    check("post_rst_idle", {hsst_txk, hsst_txd}, {4'b0001, W_IDLE});
    check("post_rst_level", fifo_level, 0);
    mon_en = 1'b1;
    f0 = frames;
    s0 = n_sof;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    wait_frames(f0 + 1);
    check("post_rst_sof_seen", n_sof, s0 + 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
